// File: rtl/uart_tx_fifo_if.sv
// Byte-write / status bundle between the MMIO bridge and the UART transmitter.
interface uart_tx_fifo_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  tx, busy, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output tx, busy, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with an 8-entry byte FIFO, LSB first, tx idles high.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 128_000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic           raw_clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned BaudW      = $clog2(ClksPerBit);
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [3:0]       count_q;
  logic             ovf_q;

  logic full, empty, push, pop, baud_done;

  assign full      = (count_q == 4'(FIFO_DEPTH));
  assign empty     = (count_q == 4'd0);
  // A write while full is dropped even if the FSM pops in the same cycle.
  assign push      = bus.wr_en & ~full;
  assign pop       = (state_q == StIdle) & ~empty;
  assign baud_done = (baud_q == BaudW'(ClksPerBit - 1));

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge raw_clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
      // Setting wins over clearing.
      if (bus.wr_en & full) ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge raw_clk) begin
    if (push) mem_q[wptr_q] <= bus.wr_data;
  end

  // Transmitter state register; tx is registered so the line never glitches.
  always_ff @(posedge raw_clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: each bit lasts ClksPerBit cycles, terminal count advances.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          shreg_d = mem_q[rptr_q];
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the upcoming cycle, derived from the next state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit.
module tb_uart_tx_fifo;
  logic raw_clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [7:0] q_data[$];
  int         q_start[$];
  bit         q_stop[$];

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_HZ    (1000),
    .BAUD      (100),
    .FIFO_DEPTH(8)
  ) dut (
    .raw_clk(raw_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 raw_clk = ~raw_clk;
  always @(posedge raw_clk) cyc <= cyc + 1;

  // Line decoder: samples mid-bit, records complete frames with their start cycle.
  initial begin : line_monitor
    logic [7:0] b;
    int         s;
    bit         ab;
    bit         stop_ok;
    int         idx;
    forever begin
      @(posedge raw_clk); #2;
      if (bus.tx === 1'b0 && rst === 1'b0) begin
        s = cyc; b = '0; ab = 1'b0; stop_ok = 1'b0;
        for (int k = 1; k < 100; k++) begin
          @(posedge raw_clk); #2;
          if (rst !== 1'b0) ab = 1'b1;
          if (k >= 15 && k <= 85 && (k % 10) == 5) begin
            idx = (k - 15) / 10;
            b[idx] = bus.tx;
          end
          if (k == 95) stop_ok = (bus.tx === 1'b1);
        end
        if (!ab) begin
          q_data.push_back(b);
          q_start.push_back(s);
          q_stop.push_back(stop_ok);
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge raw_clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && n < 3000) begin
      step(); n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL wait_idle: busy=%b empty=%b, required busy=0 empty=1", bus.busy, bus.empty);
    end
    step();
    q_data.delete(); q_start.delete(); q_stop.delete();
  endtask

  task automatic wait_frames(input int n, input int limit, input string name);
    int t = 0;
    while (q_data.size() < n && t < limit) begin
      step(); t++;
    end
    checks++;
    if (q_data.size() < n) begin
      errors++;
      $display("FAIL %s frames: got %0d, required %0d", name, q_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hFF; bus.clr_ovf = 1'b0;
    repeat (3) step();
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset tx: %b, required 1", bus.tx); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset count: %0d, required 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset empty: %b, required 1", bus.empty); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: %b, required 0", bus.overflow); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: %b, required 0", bus.busy); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset full: %b, required 0", bus.full); end
    rst = 1'b0; bus.wr_en = 1'b0;
    step();
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL post_reset tx: %b, required 1", bus.tx); end
  endtask

  task automatic test_single();
    logic [7:0] v = 8'hA5;
    logic       exp;
    int         bad;
    wait_idle();
    bus.wr_en = 1'b1; bus.wr_data = v; step(); bus.wr_en = 1'b0;
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single count_n: %0d, required 1", bus.count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single busy_n: %b, required 0", bus.busy); end
    step();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single busy_n1: %b, required 1", bus.busy); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL single count_n1: %0d, required 0", bus.count); end
    for (int p = 0; p < 10; p++) begin
      exp = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : v[p-1];
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        if (bus.tx !== exp) bad++;
        if (!(p == 9 && c == 9)) step();
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL single bit%0d: %0d cycles wrong, required tx=%b for all 10", p, bad, exp);
      end
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single busy_end: %b, required 1", bus.busy); end
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single busy_drop: %b, required 0", bus.busy); end
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL single tx_idle: %b, required 1", bus.tx); end
    wait_frames(1, 20, "single");
    if (q_data.size() >= 1) begin
      checks++;
      if (q_data[0] !== v || q_stop[0] !== 1'b1) begin
        errors++;
        $display("FAIL single decode: %h stop=%b, required a5 stop=1", q_data[0], q_stop[0]);
      end
    end
  endtask

  task automatic test_burst();
    int bad = 0;
    wait_idle();
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i); step();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL burst full: %b, required 1", bus.full); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL burst count: %0d, required 8", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL burst ovf_pre: %b, required 0", bus.overflow); end
    bus.wr_data = 8'h09; step(); bus.wr_en = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL burst ovf_set: %b, required 1", bus.overflow); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL burst count_drop: %0d, required 8", bus.count); end
    wait_frames(9, 1100, "burst");
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 8'(i)) begin
        errors++;
        $display("FAIL burst frame%0d: %h, required %h", i, q_data[i], 8'(i));
      end
    end
    for (int i = 1; i < q_start.size(); i++) if (q_start[i] - q_start[i-1] != 101) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL burst spacing: %0d gaps wrong, required 101 cycles", bad); end
  endtask

  task automatic test_wrap();
    int i = 0;
    int guard = 0;
    int bad = 0;
    bit saw_full = 1'b0;
    wait_idle();
    while (i < 20 && guard < 4000) begin
      if (bus.count < 4'd7) begin
        bus.wr_en = 1'b1; bus.wr_data = 8'(8'h30 + i); i++;
      end else begin
        bus.wr_en = 1'b0;
      end
      step(); guard++;
      if (bus.full === 1'b1) saw_full = 1'b1;
    end
    bus.wr_en = 1'b0;
    checks++; if (i != 20) begin errors++; $display("FAIL wrap pushes: %0d, required 20", i); end
    checks++; if (saw_full) begin errors++; $display("FAIL wrap full: 1, required 0"); end
    wait_frames(20, 2400, "wrap");
    for (int k = 0; k < q_data.size(); k++) if (q_data[k] !== 8'(8'h30 + k)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap order: %0d bytes wrong, required 0", bad); end
  endtask

  task automatic test_push_pop();
    int n = 0;
    logic [7:0] exp [3] = '{8'h77, 8'h11, 8'h55};
    wait_idle();
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; step(); bus.wr_en = 1'b0;
    while (bus.busy !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL pushpop start: busy=%b, required 1", bus.busy); end
    bus.wr_en = 1'b1; bus.wr_data = 8'h11; step(); bus.wr_en = 1'b0;
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL pushpop queued: %0d, required 1", bus.count); end
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin step(); n++; end
    checks++;
    if (bus.busy !== 1'b0 || bus.count !== 4'd1) begin
      errors++;
      $display("FAIL pushpop idle: busy=%b count=%0d, required busy=0 count=1", bus.busy, bus.count);
    end
    bus.wr_en = 1'b1; bus.wr_data = 8'h55; step(); bus.wr_en = 1'b0;
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL pushpop count: %0d, required 1", bus.count); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL pushpop busy: %b, required 1", bus.busy); end
    wait_frames(3, 400, "pushpop");
    for (int k = 0; k < q_data.size() && k < 3; k++) begin
      checks++;
      if (q_data[k] !== exp[k]) begin
        errors++;
        $display("FAIL pushpop frame%0d: %h, required %h", k, q_data[k], exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    wait_idle();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL midrst ovf_sticky: %b, required 1", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'hC1 + i); step();
    end
    bus.wr_en = 1'b0;
    checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL midrst queued: %0d, required 3", bus.count); end
    repeat (43) step();
    rst = 1'b1; step();
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL midrst tx: %b, required 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst busy: %b, required 0", bus.busy); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL midrst count: %0d, required 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL midrst empty: %b, required 1", bus.empty); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midrst ovf: %b, required 0", bus.overflow); end
    step(); rst = 1'b0;
    q_data.delete(); q_start.delete(); q_stop.delete();
    repeat (300) begin step(); if (bus.tx !== 1'b1) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst line: %0d low cycles, required 0", bad); end
    checks++; if (q_data.size() != 0) begin errors++; $display("FAIL midrst frames: %0d, required 0", q_data.size()); end
  endtask

  task automatic test_ovf_priority();
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'hE0 + i); step();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovfpri full: %b, required 1", bus.full); end
    bus.clr_ovf = 1'b1; bus.wr_data = 8'hEE; step();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovfpri set_wins: %b, required 1", bus.overflow); end
    bus.wr_en = 1'b0; step();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovfpri clear: %b, required 0", bus.overflow); end
    bus.wr_en = 1'b1; step();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovfpri reset_again: %b, required 1", bus.overflow); end
    bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_push_pop();
    test_reset_mid_frame();
    test_ovf_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
